// File: rtl/muldiv_arbiter_if.sv
// Issue/response bus between two requesters, the arbiter and the shared mult/div unit.
interface muldiv_arbiter_if #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned OP_W          = 7,
    parameter int unsigned TRANS_ID_BITS = 3
);
    logic                     flush_i;

    logic                     req0_valid_i;
    logic                     req0_ready_o;
    logic [OP_W-1:0]          req0_op_i;
    logic [XLEN-1:0]          req0_a_i;
    logic [XLEN-1:0]          req0_b_i;
    logic [TRANS_ID_BITS-1:0] req0_trans_id_i;

    logic                     req1_valid_i;
    logic                     req1_ready_o;
    logic [OP_W-1:0]          req1_op_i;
    logic [XLEN-1:0]          req1_a_i;
    logic [XLEN-1:0]          req1_b_i;
    logic [TRANS_ID_BITS-1:0] req1_trans_id_i;

    logic                     fu_valid_o;
    logic                     fu_ready_i;
    logic [OP_W-1:0]          fu_op_o;
    logic [XLEN-1:0]          fu_a_o;
    logic [XLEN-1:0]          fu_b_o;
    logic [TRANS_ID_BITS-1:0] fu_trans_id_o;

    logic                     fu_result_valid_i;
    logic [XLEN-1:0]          fu_result_i;
    logic [TRANS_ID_BITS-1:0] fu_result_trans_id_i;

    logic                     rsp0_valid_o;
    logic [XLEN-1:0]          rsp0_result_o;
    logic [TRANS_ID_BITS-1:0] rsp0_trans_id_o;
    logic                     rsp1_valid_o;
    logic [XLEN-1:0]          rsp1_result_o;
    logic [TRANS_ID_BITS-1:0] rsp1_trans_id_o;

    logic                     busy_o;

    // Arbiter side
    modport slave (
        input  flush_i,
        input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i, req0_trans_id_i,
        output req0_ready_o,
        input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i, req1_trans_id_i,
        output req1_ready_o,
        output fu_valid_o, fu_op_o, fu_a_o, fu_b_o, fu_trans_id_o,
        input  fu_ready_i,
        input  fu_result_valid_i, fu_result_i, fu_result_trans_id_i,
        output rsp0_valid_o, rsp0_result_o, rsp0_trans_id_o,
        output rsp1_valid_o, rsp1_result_o, rsp1_trans_id_o,
        output busy_o
    );

    // Requester/unit side
    modport master (
        output flush_i,
        output req0_valid_i, req0_op_i, req0_a_i, req0_b_i, req0_trans_id_i,
        input  req0_ready_o,
        output req1_valid_i, req1_op_i, req1_a_i, req1_b_i, req1_trans_id_i,
        input  req1_ready_o,
        input  fu_valid_o, fu_op_o, fu_a_o, fu_b_o, fu_trans_id_o,
        output fu_ready_i,
        output fu_result_valid_i, fu_result_i, fu_result_trans_id_i,
        input  rsp0_valid_o, rsp0_result_o, rsp0_trans_id_o,
        input  rsp1_valid_o, rsp1_result_o, rsp1_trans_id_o,
        input  busy_o
    );
endinterface

// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter sharing one mult/div unit between two requesters, with a
// trans_id ownership table that routes results back and bounds outstanding ops.
module muldiv_arbiter #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned OP_W          = 7,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned MAX_OUT       = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    muldiv_arbiter_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << TRANS_ID_BITS;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic [OP_W-1:0]          op;
        logic [XLEN-1:0]          a;
        logic [XLEN-1:0]          b;
        logic [TRANS_ID_BITS-1:0] id;
    } issue_t;

    logic             fu_valid_q, fu_valid_d;
    issue_t           fu_q, fu_d;
    logic [DEPTH-1:0] tbl_valid_q, tbl_valid_d;
    logic [DEPTH-1:0] tbl_owner_q, tbl_owner_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             rr_q, rr_d;

    issue_t req0_pl, req1_pl;
    logic   slot_free, not_full, elig0, elig1, grant0, grant1, rsp_hit, rsp_owner;

    assign req0_pl = '{op: bus.req0_op_i, a: bus.req0_a_i, b: bus.req0_b_i, id: bus.req0_trans_id_i};
    assign req1_pl = '{op: bus.req1_op_i, a: bus.req1_a_i, b: bus.req1_b_i, id: bus.req1_trans_id_i};

    // Eligibility, round-robin grant and response lookup
    always_comb begin
        slot_free = !fu_valid_q || bus.fu_ready_i;
        not_full  = out_cnt_q < CNT_W'(MAX_OUT);
        elig0     = bus.req0_valid_i && !tbl_valid_q[bus.req0_trans_id_i] && not_full
                    && !bus.flush_i && !rst_i;
        elig1     = bus.req1_valid_i && !tbl_valid_q[bus.req1_trans_id_i] && not_full
                    && !bus.flush_i && !rst_i;
        grant0    = slot_free && elig0 && (!elig1 || !rr_q);
        grant1    = slot_free && elig1 && (!elig0 || rr_q);
        rsp_hit   = bus.fu_result_valid_i && tbl_valid_q[bus.fu_result_trans_id_i]
                    && !bus.flush_i && !rst_i;
        rsp_owner = tbl_owner_q[bus.fu_result_trans_id_i];
    end

    // Next state: the response clear and the accept set never touch the same id
    always_comb begin
        fu_valid_d  = fu_valid_q;
        fu_d        = fu_q;
        tbl_valid_d = tbl_valid_q;
        tbl_owner_d = tbl_owner_q;
        out_cnt_d   = out_cnt_q;
        rr_d        = rr_q;
        if (bus.flush_i) begin
            fu_valid_d  = 1'b0;
            tbl_valid_d = '0;
            out_cnt_d   = '0;
        end else begin
            if (bus.fu_ready_i) begin
                fu_valid_d = 1'b0;
            end
            if (rsp_hit) begin
                tbl_valid_d[bus.fu_result_trans_id_i] = 1'b0;
            end
            if (grant0 || grant1) begin
                fu_valid_d           = 1'b1;
                fu_d                 = grant1 ? req1_pl : req0_pl;
                tbl_valid_d[fu_d.id] = 1'b1;
                tbl_owner_d[fu_d.id] = grant1;
                rr_d                 = !grant1;
            end
            out_cnt_d = out_cnt_q + CNT_W'(grant0 || grant1) - CNT_W'(rsp_hit);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fu_valid_q  <= 1'b0;
            fu_q        <= '0;
            tbl_valid_q <= '0;
            tbl_owner_q <= '0;
            out_cnt_q   <= '0;
            rr_q        <= 1'b0;
        end else begin
            fu_valid_q  <= fu_valid_d;
            fu_q        <= fu_d;
            tbl_valid_q <= tbl_valid_d;
            tbl_owner_q <= tbl_owner_d;
            out_cnt_q   <= out_cnt_d;
            rr_q        <= rr_d;
        end
    end

    assign bus.req0_ready_o    = grant0;
    assign bus.req1_ready_o    = grant1;
    assign bus.fu_valid_o      = fu_valid_q;
    assign bus.fu_op_o         = fu_q.op;
    assign bus.fu_a_o          = fu_q.a;
    assign bus.fu_b_o          = fu_q.b;
    assign bus.fu_trans_id_o   = fu_q.id;
    assign bus.rsp0_valid_o    = rsp_hit && !rsp_owner;
    assign bus.rsp1_valid_o    = rsp_hit && rsp_owner;
    assign bus.rsp0_result_o   = bus.fu_result_i;
    assign bus.rsp1_result_o   = bus.fu_result_i;
    assign bus.rsp0_trans_id_o = bus.fu_result_trans_id_i;
    assign bus.rsp1_trans_id_o = bus.fu_result_trans_id_i;
    assign bus.busy_o          = fu_valid_q || (out_cnt_q != '0);
endmodule

// File: tb/tb_muldiv_arbiter.sv
// Scoreboard bench: a queue/map-based model predicts grants, unit issues and
// routed responses; a separate monitor compares what the DUT presents.
module tb_muldiv_arbiter;
    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 7;
    localparam int unsigned IDB  = 3;
    localparam int unsigned MAXO = 4;

    typedef struct {
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [IDB-1:0]  id;
    } fu_t;

    typedef struct {
        int unsigned     who;
        logic [XLEN-1:0] res;
        logic [IDB-1:0]  id;
    } rsp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    muldiv_arbiter_if #(.XLEN(XLEN), .OP_W(OP_W), .TRANS_ID_BITS(IDB)) bus ();

    muldiv_arbiter #(.XLEN(XLEN), .OP_W(OP_W), .TRANS_ID_BITS(IDB), .MAX_OUT(MAXO)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference state: who owns each live id, whether the issue stage holds an op
    int unsigned    owner [int unsigned];
    bit             stage_busy = 1'b0;
    int unsigned    rr = 0;
    logic [1:0]     exp_ready_q [$];
    fu_t            fu_exp_q [$];
    rsp_t           rsp_exp_q [$];
    bit             exp_fu_valid, exp_busy;
    logic [IDB-1:0] unit_inflight [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.flush_i              = 1'b0;
        bus.req0_valid_i         = 1'b0;
        bus.req0_op_i            = '0;
        bus.req0_a_i             = '0;
        bus.req0_b_i             = '0;
        bus.req0_trans_id_i      = '0;
        bus.req1_valid_i         = 1'b0;
        bus.req1_op_i            = '0;
        bus.req1_a_i             = '0;
        bus.req1_b_i             = '0;
        bus.req1_trans_id_i      = '0;
        bus.fu_ready_i           = 1'b1;
        bus.fu_result_valid_i    = 1'b0;
        bus.fu_result_i          = '0;
        bus.fu_result_trans_id_i = '0;
    endtask

    task automatic set_req0(input logic [OP_W-1:0] op, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input logic [IDB-1:0] id);
        bus.req0_valid_i = 1'b1; bus.req0_op_i = op; bus.req0_a_i = a;
        bus.req0_b_i = b; bus.req0_trans_id_i = id;
    endtask

    task automatic set_req1(input logic [OP_W-1:0] op, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input logic [IDB-1:0] id);
        bus.req1_valid_i = 1'b1; bus.req1_op_i = op; bus.req1_a_i = a;
        bus.req1_b_i = b; bus.req1_trans_id_i = id;
    endtask

    // The unit hands back a result for id; forget one matching in-flight entry
    task automatic give_result(input logic [IDB-1:0] id, input logic [XLEN-1:0] data);
        bus.fu_result_valid_i    = 1'b1;
        bus.fu_result_trans_id_i = id;
        bus.fu_result_i          = data;
        for (int i = 0; i < unit_inflight.size(); i++) begin
            if (unit_inflight[i] == id) begin
                unit_inflight.delete(i);
                break;
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            clear_inputs();
            if (unit_inflight.size() > 0) give_result(unit_inflight[0], $urandom);
        end
    endtask

    // Reference model: evaluated once per cycle with the cycle's inputs settled
    initial forever begin
        int g;
        bit e0, e1, full;
        @(negedge clk_i);
        #1;
        exp_fu_valid = stage_busy;
        exp_busy     = stage_busy || (owner.num() != 0);
        if (rst_i) begin
            owner.delete();
            stage_busy   = 1'b0;
            rr           = 0;
            fu_exp_q.delete();
            exp_fu_valid = 1'b0;
            exp_busy     = 1'b0;
            exp_ready_q.push_back(2'b00);
        end else begin
            full = owner.num() >= MAXO;
            e0 = bus.req0_valid_i && !owner.exists(int'(bus.req0_trans_id_i)) && !full && !bus.flush_i;
            e1 = bus.req1_valid_i && !owner.exists(int'(bus.req1_trans_id_i)) && !full && !bus.flush_i;
            g = -1;
            if (!stage_busy || bus.fu_ready_i) begin
                if (e0 && e1)  g = int'(rr);
                else if (e0)   g = 0;
                else if (e1)   g = 1;
            end
            exp_ready_q.push_back(g == 0 ? 2'b01 : (g == 1 ? 2'b10 : 2'b00));
            if (bus.flush_i) begin
                owner.delete();
                stage_busy = 1'b0;
                fu_exp_q.delete();
            end else begin
                if (bus.fu_result_valid_i && owner.exists(int'(bus.fu_result_trans_id_i))) begin
                    rsp_exp_q.push_back('{owner[int'(bus.fu_result_trans_id_i)],
                                          bus.fu_result_i, bus.fu_result_trans_id_i});
                    owner.delete(int'(bus.fu_result_trans_id_i));
                end
                if (bus.fu_ready_i) stage_busy = 1'b0;
                if (g == 0) begin
                    owner[int'(bus.req0_trans_id_i)] = 0;
                    fu_exp_q.push_back('{bus.req0_op_i, bus.req0_a_i, bus.req0_b_i, bus.req0_trans_id_i});
                end else if (g == 1) begin
                    owner[int'(bus.req1_trans_id_i)] = 1;
                    fu_exp_q.push_back('{bus.req1_op_i, bus.req1_a_i, bus.req1_b_i, bus.req1_trans_id_i});
                end
                if (g >= 0) begin
                    stage_busy = 1'b1;
                    rr         = (g == 0) ? 1 : 0;
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model's queues each cycle
    initial forever begin
        logic [1:0] er;
        fu_t        hf;
        rsp_t       hr;
        @(negedge clk_i);
        #3;
        er = exp_ready_q.pop_front();
        check("req_ready", {bus.req1_ready_o, bus.req0_ready_o}, er);
        check("fu_valid", bus.fu_valid_o, exp_fu_valid);
        check("busy", bus.busy_o, exp_busy);
        if (rst_i) begin
            check("reset_fu_op", bus.fu_op_o, 0);
            check("reset_fu_ab", {bus.fu_a_o, bus.fu_b_o}, 0);
            check("reset_fu_id", bus.fu_trans_id_o, 0);
        end
        if (bus.fu_valid_o && !bus.flush_i && !rst_i) begin
            if (fu_exp_q.size() == 0) begin
                check("fu_unexpected_issue", 1, 0);
            end else begin
                hf = fu_exp_q[0];
                check("fu_op", bus.fu_op_o, hf.op);
                check("fu_a", bus.fu_a_o, hf.a);
                check("fu_b", bus.fu_b_o, hf.b);
                check("fu_id", bus.fu_trans_id_o, hf.id);
                if (bus.fu_ready_i) begin
                    void'(fu_exp_q.pop_front());
                    unit_inflight.push_back(hf.id);
                end
            end
        end
        if (bus.rsp0_valid_o || bus.rsp1_valid_o) begin
            if (bus.rsp0_valid_o && bus.rsp1_valid_o) begin
                check("rsp_both_valid", 1, 0);
            end else if (rsp_exp_q.size() == 0) begin
                check("rsp_unexpected", {bus.rsp1_valid_o, bus.rsp0_valid_o}, 0);
            end else begin
                hr = rsp_exp_q.pop_front();
                check("rsp_owner", bus.rsp1_valid_o ? 1 : 0, hr.who);
                check("rsp_result", bus.rsp1_valid_o ? bus.rsp1_result_o : bus.rsp0_result_o, hr.res);
                check("rsp_id", bus.rsp1_valid_o ? bus.rsp1_trans_id_o : bus.rsp0_trans_id_o, hr.id);
            end
        end
        check("rsp_missing", rsp_exp_q.size(), 0);
        rsp_exp_q.delete();
    end

    initial begin
        clear_inputs();
        set_req0(7'd1, 32'd1, 32'd2, 3'd0);
        set_req1(7'd1, 32'd3, 32'd4, 3'd1);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        clear_inputs();

        // Single op: MUL 10*20, id 1, result 200
        @(negedge clk_i); clear_inputs(); set_req0(7'd1, 32'd10, 32'd20, 3'd1);
        @(negedge clk_i); clear_inputs();
        @(negedge clk_i); clear_inputs(); give_result(3'd1, 32'd200);
        repeat (2) begin @(negedge clk_i); clear_inputs(); end

        // Fresh reset, both request every cycle, then hit the outstanding limit
        @(negedge clk_i); rst_i = 1'b1; clear_inputs();
        @(negedge clk_i); rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i); clear_inputs();
            set_req0(7'd1, $urandom, $urandom, IDB'(c));
            set_req1(7'd1, $urandom, $urandom, IDB'(c + 4));
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i); clear_inputs();
            set_req0(7'd1, 32'd7, 32'd8, 3'd1);
            set_req1(7'd1, 32'd9, 32'd6, 3'd3);
            if (c == 2) give_result(3'd0, 32'h1234);
        end
        @(negedge clk_i); clear_inputs();
        set_req0(7'd1, 32'd7, 32'd8, 3'd1);
        set_req1(7'd1, 32'd9, 32'd6, 3'd3);
        drain(12);

        // Backpressure: unit stalls three cycles while both keep requesting
        @(negedge clk_i); clear_inputs(); set_req0(7'd3, 32'd11, 32'd12, 3'd2);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i); clear_inputs();
            bus.fu_ready_i = (c == 3);
            set_req0(7'd1, 32'd21, 32'd22, 3'd4);
            set_req1(7'd1, 32'd31, 32'd32, 3'd6);
        end
        drain(10);

        // Out-of-order return across requesters
        @(negedge clk_i); clear_inputs(); set_req0(7'd2, 32'd100, 32'd7, 3'd2);
        @(negedge clk_i); clear_inputs(); set_req1(7'd1, 32'd5, 32'd6, 3'd5);
        repeat (2) begin @(negedge clk_i); clear_inputs(); end
        @(negedge clk_i); clear_inputs(); give_result(3'd5, 32'd30);
        @(negedge clk_i); clear_inputs(); give_result(3'd2, 32'd14);
        drain(4);

        // Flush with two in flight, stale result dropped, id reused at once
        @(negedge clk_i); clear_inputs(); set_req0(7'd1, 32'd1, 32'd1, 3'd3);
        @(negedge clk_i); clear_inputs(); set_req1(7'd1, 32'd2, 32'd2, 3'd4);
        @(negedge clk_i); clear_inputs();
        @(negedge clk_i); clear_inputs(); bus.flush_i = 1'b1;
        set_req0(7'd1, 32'd3, 32'd3, 3'd5);
        @(negedge clk_i); clear_inputs(); give_result(3'd3, 32'hdead);
        @(negedge clk_i); clear_inputs(); set_req0(7'd1, 32'd4, 32'd4, 3'd3);
        drain(8);

        // Randomized traffic with occasional flush, bogus results and a mid-run reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i); clear_inputs();
            rst_i = (c >= 1500 && c < 1502);
            if ($urandom_range(0, 3) != 0)
                set_req0(OP_W'($urandom_range(0, 127)), $urandom, $urandom, IDB'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) != 0)
                set_req1(OP_W'($urandom_range(0, 127)), $urandom, $urandom, IDB'($urandom_range(0, 7)));
            bus.fu_ready_i = ($urandom_range(0, 3) != 0);
            bus.flush_i    = ($urandom_range(0, 59) == 0);
            if (unit_inflight.size() > 0 && $urandom_range(0, 2) == 0)
                give_result(unit_inflight[$urandom_range(0, unit_inflight.size() - 1)], $urandom);
            else if ($urandom_range(0, 19) == 0)
                give_result(IDB'($urandom_range(0, 7)), $urandom);
        end
        drain(20);
        @(negedge clk_i); clear_inputs();
        #4;
        check("final_fu_queue_empty", fu_exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
